// File: rtl/tpu_quant_pkg.sv
// Shared constants, state encoding and helpers for the quantizing write-back controller.
// Optional saturation counting is selected with QUANT_SAT_COUNT_EN (see quant_writeback_ctrl).
package tpu_quant_pkg;

    localparam int ARRAY_SIZE        = 8;
    localparam int SRAM_DATA_WIDTH   = 32;
    localparam int DATA_WIDTH        = 8;
    localparam int OUTPUT_DATA_WIDTH = 16;
    localparam int CUM_BITS_EXT      = 5;
    localparam int ORI_WIDTH         = 2 * DATA_WIDTH + CUM_BITS_EXT;
    localparam int ADDR_WIDTH        = 10;
    localparam int BEATS             = ARRAY_SIZE * OUTPUT_DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int ROW_WIDTH         = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int ROW_CNT_W         = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int BEAT_CNT_W        = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [OUTPUT_DATA_WIDTH-1:0] QMAX = {1'b0, {(OUTPUT_DATA_WIDTH-1){1'b1}}};
    localparam logic [OUTPUT_DATA_WIDTH-1:0] QMIN = {1'b1, {(OUTPUT_DATA_WIDTH-1){1'b0}}};
    // Clamp bounds sign-extended to the accumulator lane width for signed compares.
    localparam logic signed [ORI_WIDTH-1:0] QMAX_EXT = ORI_WIDTH'(signed'(QMAX));
    localparam logic signed [ORI_WIDTH-1:0] QMIN_EXT = ORI_WIDTH'(signed'(QMIN));

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } wb_state_e;

    function automatic logic [15:0] count_ones(input logic [ARRAY_SIZE-1:0] flags);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            n = n + {15'd0, flags[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [15:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/lane_saturate.sv
// Combinational signed clamp of one accumulator lane to the quantized output width.
// With QUANT_SAT_COUNT_EN defined it also flags lanes that took a clamp branch.
module lane_saturate
    import tpu_quant_pkg::*;
(
    input  logic [ORI_WIDTH-1:0]         i_lane,
`ifdef QUANT_SAT_COUNT_EN
    output logic                         o_sat,
`endif
    output logic [OUTPUT_DATA_WIDTH-1:0] o_q
);

    logic signed [ORI_WIDTH-1:0] w_x;
    logic                        w_sat;

    assign w_x = signed'(i_lane);

    // Clamp to the signed output range; in-range values pass their low bits.
    always_comb begin
        o_q   = i_lane[OUTPUT_DATA_WIDTH-1:0];
        w_sat = 1'b0;
        if (w_x >= QMAX_EXT) begin
            o_q   = QMAX;
            w_sat = 1'b1;
        end else if (w_x <= QMIN_EXT) begin
            o_q   = QMIN;
            w_sat = 1'b1;
        end else begin
            o_q   = i_lane[OUTPUT_DATA_WIDTH-1:0];
            w_sat = 1'b0;
        end
    end

`ifdef QUANT_SAT_COUNT_EN
    assign o_sat = w_sat;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat;
`endif

endmodule

// File: rtl/quant_writeback_ctrl.sv
// Writes one quantized output tile (ARRAY_SIZE rows, BEATS SRAM words per row) to SRAM.
// Define QUANT_SAT_COUNT_EN to add the per-tile saturated-lane counter output sat_count.
module quant_writeback_ctrl
    import tpu_quant_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic                             acc_valid,
    output logic                             acc_ready,
    input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]  acc_data,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]       sram_wdata,
`ifdef QUANT_SAT_COUNT_EN
    output logic [15:0]                      sat_count,
`endif
    output logic                             busy,
    output logic                             done
);

    wb_state_e               r_state;
    wb_state_e               w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ROW_CNT_W-1:0]    r_row_cnt;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic [ROW_WIDTH-1:0]    r_row_buf;
    logic [ROW_WIDTH-1:0]    w_sat_row;
    logic [ARRAY_SIZE-1:0]   w_sat_flags;
    logic                    w_last_beat;
    logic                    w_last_row;
    logic                    w_take_row;

    genvar g;
    for (g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        lane_saturate u_sat (
            .i_lane (acc_data[g*ORI_WIDTH +: ORI_WIDTH]),
`ifdef QUANT_SAT_COUNT_EN
            .o_sat  (w_sat_flags[g]),
`endif
            .o_q    (w_sat_row[g*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH])
        );
`ifndef QUANT_SAT_COUNT_EN
        assign w_sat_flags[g] = 1'b0;
`endif
    end

    assign w_last_beat = (r_beat_cnt == BEAT_CNT_W'(BEATS - 1));
    assign w_last_row  = (r_row_cnt == ROW_CNT_W'(ARRAY_SIZE - 1));
    assign w_take_row  = (r_state == ST_WAIT_ROW) && acc_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_WAIT_ROW;
                else       w_state_nxt = ST_IDLE;
            end
            ST_WAIT_ROW: begin
                if (acc_valid) w_state_nxt = ST_WRITE;
                else           w_state_nxt = ST_WAIT_ROW;
            end
            ST_WRITE: begin
                if (w_last_beat) w_state_nxt = w_last_row ? ST_DONE : ST_WAIT_ROW;
                else             w_state_nxt = ST_WRITE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address, row/beat counters and quantized row buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_row_cnt  <= '0;
            r_beat_cnt <= '0;
            r_row_buf  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr    <= base_addr;
                        r_row_cnt <= '0;
                    end
                end
                ST_WAIT_ROW: begin
                    if (acc_valid) begin
                        r_row_buf  <= w_sat_row;
                        r_beat_cnt <= '0;
                    end
                end
                ST_WRITE: begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                    if (w_last_beat) begin
                        if (!w_last_row) r_row_cnt <= r_row_cnt + ROW_CNT_W'(1);
                    end else begin
                        r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                    end
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

`ifdef QUANT_SAT_COUNT_EN
    logic [15:0] r_sat_count;

    // Per-tile saturated-lane count, sticky at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= 16'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_sat_count <= 16'd0;
        end else if (w_take_row) begin
            r_sat_count <= sat_add16(r_sat_count, count_ones(w_sat_flags));
        end else begin
            r_sat_count <= r_sat_count;
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_flags;
    assign w_unused_flags = (|w_sat_flags) | w_take_row;
`endif

    assign acc_ready  = (r_state == ST_WAIT_ROW);
    assign sram_we    = (r_state == ST_WRITE);
    assign sram_addr  = r_addr;
    assign sram_wdata = r_row_buf[int'(r_beat_cnt)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
    assign busy       = (r_state == ST_WAIT_ROW) || (r_state == ST_WRITE);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_quant_writeback_ctrl.sv
// Directed self-checking bench for quant_writeback_ctrl: tiles, saturation, wrap, backpressure, reset.
module tb_quant_writeback_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [9:0]   base_addr;
    logic         acc_valid;
    logic         acc_ready;
    logic [167:0] acc_data;
    logic         sram_we;
    logic [9:0]   sram_addr;
    logic [31:0]  sram_wdata;
    logic         busy;
    logic         done;
`ifdef QUANT_SAT_COUNT_EN
    logic [15:0]  sat_count;
`endif

    int n_total = 0;
    int n_bad   = 0;

    int           rows [8][8];
    logic [31:0]  obs_data [32];
    logic [9:0]   obs_addr [32];
    int           done_k;
    int           wr_cnt;

    quant_writeback_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
`ifdef QUANT_SAT_COUNT_EN
        .sat_count  (sat_count),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int x);
        logic [31:0] v;
        v = x;
        if (x >= 32767)       return 16'h7FFF;
        else if (x <= -32768) return 16'h8000;
        else                  return v[15:0];
    endfunction

    function automatic logic [167:0] pack_row(input int r);
        logic [167:0] p;
        logic [31:0]  v;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            v = rows[r][i];
            p[i*21 +: 21] = v[20:0];
        end
        return p;
    endfunction

    // Runs one tile from a negedge; abort_at >= 0 asserts reset at that write index.
    task automatic run_tile(input logic [9:0] base, input bit gaps, input bit start_mid,
                            input int abort_at);
        logic [31:0] exp_data [32];
        logic [9:0]  exp_addr [32];
        int k, ri, dn;
        bit aborted;
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 4; b++) begin
                exp_data[r*4+b] = {sat16(rows[r][2*b+1]), sat16(rows[r][2*b])};
                exp_addr[r*4+b] = base + 10'(r*4+b);
            end
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; base_addr = base; acc_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        k = 1; wr_cnt = 0; ri = 0; dn = 0; done_k = 0; aborted = 1'b0;
        while (k < 400 && dn == 0 && !aborted) begin
            start = 1'b0;
            if (sram_we) begin
                if (wr_cnt < 32) begin
                    obs_data[wr_cnt] = sram_wdata;
                    obs_addr[wr_cnt] = sram_addr;
                    chk($sformatf("addr%0d", wr_cnt), {22'd0, sram_addr}, {22'd0, exp_addr[wr_cnt]});
                    chk($sformatf("data%0d", wr_cnt), sram_wdata, exp_data[wr_cnt]);
                end else begin
                    chk("extra_write", 32'(wr_cnt), 32'd31);
                end
                if (acc_ready) chk("ready_during_write", 32'd1, 32'd0);
                if (start_mid && wr_cnt == 5) begin
                    start = 1'b1; base_addr = 10'h2AA;
                end
                if (wr_cnt == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_we", {31'd0, sram_we}, 32'd0);
                    chk("rst_busy", {31'd0, busy}, 32'd0);
                    chk("rst_ready", {31'd0, acc_ready}, 32'd0);
                    aborted = 1'b1;
                end
                wr_cnt++;
            end
            if (done) begin
                dn++;
                done_k = k;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (ri < 8 && (!gaps || $urandom_range(0, 2) != 0)) begin
                acc_valid = 1'b1;
                acc_data  = pack_row(ri);
            end else begin
                acc_valid = 1'b0;
            end
            if (acc_ready && acc_valid && !aborted) ri++;
            if (!aborted) begin
                @(negedge clk);
                k++;
            end
        end
        acc_valid = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            chk("write_count", 32'(wr_cnt), 32'd32);
            chk("done_seen", 32'(dn), 32'd1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("post_we", {31'd0, sram_we}, 32'd0);
                chk("post_busy", {31'd0, busy}, 32'd0);
                chk("post_done", {31'd0, done}, 32'd0);
            end
        end
    endtask

    task automatic fill_rows(input int seed);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                rows[r][i] = seed + r * 100 + i * 7 - 20;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; acc_valid = 1'b0; acc_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, acc_ready}, 32'd0);
        chk("rst_we", {31'd0, sram_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {22'd0, sram_addr}, 32'd0);
        chk("rst_wdata", sram_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic gapless tile at 0x100.
        fill_rows(0);
        run_tile(10'h100, 1'b0, 1'b0, -1);
        chk("basic_done_cycle", 32'(done_k), 32'd41);
        chk("basic_first_addr", {22'd0, obs_addr[0]}, 32'h100);
        chk("basic_last_addr", {22'd0, obs_addr[31]}, 32'h11F);
        chk("basic_b0", obs_data[0], 32'hFFF3_FFEC);

        // Saturation and exact-boundary rows, back-to-back start right after the previous tile.
        fill_rows(5);
        rows[0][0] = 40000; rows[0][1] = -40000; rows[0][2] = 1234; rows[0][3] = -1;
        for (int i = 4; i < 8; i++) rows[0][i] = 0;
        for (int i = 0; i < 8; i++) rows[1][i] = 0;
        rows[1][0] = 32767; rows[1][1] = -32768; rows[1][2] = 32766; rows[1][3] = -32767;
        rows[2][0] = 1048575; rows[2][1] = -1048576;
        run_tile(10'h000, 1'b0, 1'b0, -1);
        chk("sat_b0", obs_data[0], 32'h8000_7FFF);
        chk("sat_b1", obs_data[1], 32'hFFFF_04D2);
        chk("sat_b2", obs_data[2], 32'h0000_0000);
        chk("bound_b0", obs_data[4], 32'h8000_7FFF);
        chk("bound_b1", obs_data[5], 32'h8001_7FFE);
        chk("ext_b0", obs_data[8], 32'h8000_7FFF);

        // Address wrap with no stall.
        fill_rows(-300);
        run_tile(10'h3F0, 1'b0, 1'b0, -1);
        chk("wrap_done_cycle", 32'(done_k), 32'd41);
        chk("wrap_addr15", {22'd0, obs_addr[15]}, 32'h3FF);
        chk("wrap_addr16", {22'd0, obs_addr[16]}, 32'h000);
        chk("wrap_addr31", {22'd0, obs_addr[31]}, 32'h00F);

        // Random acc_valid gaps and a start pulse during WRITE.
        fill_rows(1000);
        run_tile(10'h050, 1'b1, 1'b1, -1);
        chk("gap_last_addr", {22'd0, obs_addr[31]}, 32'h06F);

        // Reset at row 3 beat 2, then a fresh full tile.
        fill_rows(77);
        run_tile(10'h200, 1'b0, 1'b0, 14);
        chk("abort_at_addr", {22'd0, obs_addr[14]}, 32'h20E);
        @(negedge clk);
        chk("in_rst_we", {31'd0, sram_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        fill_rows(-5000);
        run_tile(10'h000, 1'b0, 1'b0, -1);
        chk("fresh_done_cycle", 32'(done_k), 32'd41);
        chk("fresh_last_addr", {22'd0, obs_addr[31]}, 32'h01F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/quant_writeback_ctrl.md
Name: quant_writeback_ctrl

Overview:
Sequences write-back of one systolic-array output tile (ARRAY_SIZE accumulator rows) into the output SRAM.
- Accepts accumulator rows over a valid/ready handshake.
- Saturates each lane from ORI_WIDTH to OUTPUT_DATA_WIDTH.
- Splits each quantized row into SRAM_DATA_WIDTH beats and issues sequential SRAM writes from a programmable base address.
- Sits between the array's accumulator drain and the output SRAM write port; started by the top-level tile scheduler.

Parameters:
- ARRAY_SIZE, 8, lanes per row and rows per tile.
- SRAM_DATA_WIDTH, 32, SRAM word width.
- DATA_WIDTH, 8, operand width.
- OUTPUT_DATA_WIDTH, 16, quantized lane width.
- CUM_BITS_EXT, 5, accumulator growth bits.
- ORI_WIDTH, 2*DATA_WIDTH+CUM_BITS_EXT, accumulator lane width.
- ADDR_WIDTH, 10, SRAM address width.
- BEATS, ARRAY_SIZE*OUTPUT_DATA_WIDTH/SRAM_DATA_WIDTH (=4), SRAM writes per row. Must be an integer ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  tile start pulse.
- base_addr  in  ADDR_WIDTH  first SRAM address of tile.
- acc_valid  in  1  row available.
- acc_ready  out  1  controller accepts row.
- acc_data  in  ARRAY_SIZE*ORI_WIDTH  signed lanes; lane i at [i*ORI_WIDTH +: ORI_WIDTH].
- sram_we  out  1  write strobe, active high.
- sram_addr  out  ADDR_WIDTH  write address.
- sram_wdata  out  SRAM_DATA_WIDTH  write data.
- busy  out  1  tile in progress.
- done  out  1  one-cycle tile-complete pulse.

Behaviour:
- Reset: FSM=IDLE; acc_ready, sram_we, busy, done=0; sram_addr, sram_wdata=0; row_cnt, beat_cnt=0; row buffer cleared. All outputs are registered or decoded from registered state only.
- States: IDLE, WAIT_ROW, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr into addr_reg, clears row_cnt, goes to WAIT_ROW.
  - busy=1 from the next cycle.
- WAIT_ROW:
  - acc_ready=1.
  - On acc_valid&&acc_ready: saturate all lanes into row_buf, beat_cnt=0, go to WRITE.
  - acc_valid low: stay indefinitely.
- Saturation per lane, signed:
  - x ≥ 2^(OUT-1)-1 → 0x7FFF.
  - x ≤ -2^(OUT-1) → 0x8000.
  - Otherwise low OUTPUT_DATA_WIDTH bits.
- WRITE, one beat per cycle:
  - sram_we=1, sram_addr=addr_reg, sram_wdata=row_buf[beat_cnt*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH]. Beat 0 = lanes 0..1, lowest lane in LSBs.
  - addr_reg++ per beat; wraps modulo 2^ADDR_WIDTH with no error.
  - At beat_cnt==BEATS-1: if row_cnt==ARRAY_SIZE-1 go to DONE, else row_cnt++ and go to WAIT_ROW.
- Latency and throughput: row handshake at cycle t → first write at t+1, last write at t+BEATS. One row per BEATS+1 cycles; tile = ARRAY_SIZE*(BEATS+1) cycles minimum.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- A new start is accepted in IDLE in the cycle immediately after DONE.
- start while not IDLE: ignored; base_addr is not re-latched.
- acc_ready is 0 in IDLE, WRITE and DONE; acc_valid is ignored there and the source must hold data.
- Async reset mid-tile: immediate return to reset state. sram_we drops asynchronously; no further writes; partial tile is abandoned.

Optional Feature:
- Macro: QUANT_SAT_COUNT_EN.
- Defined:
  - Adds output sat_count [15:0], registered.
  - Counts saturated lanes (either bound) per tile; a row can add up to ARRAY_SIZE in one cycle.
  - Cleared on start acceptance; saturates at 0xFFFF; holds after DONE.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package tpu_quant_pkg:
  - State encoding enum (IDLE/WAIT_ROW/WRITE/DONE).
  - Derived ORI_WIDTH and BEATS localparams.
  - QMAX/QMIN constants derived from OUTPUT_DATA_WIDTH.
- One sub-module, lane_saturate: combinational single-lane clamp, generated ARRAY_SIZE times. When QUANT_SAT_COUNT_EN is defined it also outputs a saturated flag.

Test Plan:
- Basic tile: base_addr=0x100, 8 rows, acc_valid always 1 → 32 writes at 0x100..0x11F. done pulses once, 8*5 cycles after the start+1 cycle. busy is low before and after.
- Saturation: lanes 0..3 = +40000, -40000, 1234, -1 → beat 0 = 0x8000_7FFF, beat 1 = 0xFFFF_04D2. With QUANT_SAT_COUNT_EN, sat_count=2 after the tile.
- Boundaries: lanes = 32767, -32768, 32766, -32767 → 0x8000_7FFF, 0x8001_7FFE.
- Wrap: base_addr=0x3F0 → addresses 0x3F0..0x3FF, then 0x000..0x00F. No stall.
- Backpressure/start: random acc_valid gaps, start pulsed during WRITE → start ignored, write sequence unchanged, no writes while in WAIT_ROW.
- Reset mid-op: rst_n low during row 3 beat 2 → sram_we=0 immediately, busy=0. A fresh start after release completes a full correct tile.
